// File: rtl/color_wheel_fader.sv
// color_wheel_fader
// Walks a 6-segment RGB hue wheel and produces brightness-scaled, registered
// per-channel duty values for PWM LED drivers.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   en                   1 = advance the wheel, 0 = hold position and tick
//   dir                  0 = forward (seg 0->5), 1 = reverse
//   sync_clr             synchronous restart to seg 0, step 0, tick 0
//   brightness[7:0]      global scale, 255 = unscaled
//   duty_r/g/b[DW-1:0]   scaled, registered duty values
//   seg[2:0]             current segment 0..5
//   step_pulse           one-cycle strobe after each position advance
//   wrap_pulse           one-cycle strobe on a 5->0 (fwd) or 0->5 (rev) step
//   pwm_r/g/b            PWM pin outputs, only with COLOR_WHEEL_PWM_OUT_EN
//
// Optional feature macro: COLOR_WHEEL_PWM_OUT_EN adds an internal free-running
// PWM counter and direct PWM pin outputs.
module color_wheel_fader #(
    parameter int CLK_FREQ      = 12000000,
    parameter int PERIOD_MS     = 1000,
    parameter int STEPS_PER_SEG = 200,
    parameter int PWM_INTERVAL  = 1200,
    localparam int DW           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          dir,
    input  logic          sync_clr,
    input  logic [7:0]    brightness,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic [2:0]    seg,
    output logic          step_pulse,
    output logic          wrap_pulse
`ifdef COLOR_WHEEL_PWM_OUT_EN
    ,
    output logic          pwm_r,
    output logic          pwm_g,
    output logic          pwm_b
`endif
);

    // 64-bit intermediate: CLK_FREQ*PERIOD_MS overflows 32 bits at typical rates.
    localparam longint TICK_DIV = longint'(CLK_FREQ) * longint'(PERIOD_MS) / 1000
                                  / longint'(6 * STEPS_PER_SEG);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (STEPS_PER_SEG > 1) ? $clog2(STEPS_PER_SEG) : 1;
    localparam int INC = PWM_INTERVAL / STEPS_PER_SEG;
    localparam int PW = DW + 9;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_SEG - 1);
    localparam logic [DW-1:0] DUTY_MAX  = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] DUTY_INC  = DW'(INC);

    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] step_q, step_d;
    logic [2:0]    seg_q, seg_d;
    logic          step_pulse_q, step_pulse_d;
    logic          wrap_pulse_q, wrap_pulse_d;
    logic [DW-1:0] duty_r_q, duty_r_d;
    logic [DW-1:0] duty_g_q, duty_g_d;
    logic [DW-1:0] duty_b_q, duty_b_d;

    logic [DW-1:0] rise, fall;
    logic [DW-1:0] raw_r, raw_g, raw_b;
    logic [8:0]    scale;
    logic [PW-1:0] prod_r, prod_g, prod_b;

    // Position sequencer. sync_clr wins over a coincident strobe.
    always_comb begin
        tick_d       = tick_q;
        step_d       = step_q;
        seg_d        = seg_q;
        step_pulse_d = 1'b0;
        wrap_pulse_d = 1'b0;
        if (sync_clr) begin
            tick_d = '0;
            step_d = '0;
            seg_d  = 3'd0;
        end else if (en) begin
            if (tick_q == TICK_LAST) begin
                tick_d       = '0;
                step_pulse_d = 1'b1;
                if (!dir) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (seg_q == 3'd5) begin
                            seg_d        = 3'd0;
                            wrap_pulse_d = 1'b1;
                        end else begin
                            seg_d = seg_q + 3'd1;
                        end
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end else begin
                    if (step_q == '0) begin
                        step_d = STEP_LAST;
                        if (seg_q == 3'd0) begin
                            seg_d        = 3'd5;
                            wrap_pulse_d = 1'b1;
                        end else begin
                            seg_d = seg_q - 3'd1;
                        end
                    end else begin
                        step_d = step_q - SW'(1);
                    end
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    // Raw hue wheel duty and brightness scaling.
    always_comb begin
        rise  = DW'(step_q) * DUTY_INC;
        fall  = DUTY_MAX - rise;
        raw_r = '0;
        raw_g = '0;
        raw_b = '0;
        case (seg_q)
            3'd0: begin raw_r = DUTY_MAX; raw_g = rise;     end
            3'd1: begin raw_r = fall;     raw_g = DUTY_MAX; end
            3'd2: begin raw_g = DUTY_MAX; raw_b = rise;     end
            3'd3: begin raw_g = fall;     raw_b = DUTY_MAX; end
            3'd4: begin raw_r = rise;     raw_b = DUTY_MAX; end
            3'd5: begin raw_r = DUTY_MAX; raw_b = fall;     end
            default: ;
        endcase
        // raw <= M and scale <= 256, so the shifted product always fits DW bits.
        scale    = {1'b0, brightness} + 9'd1;
        prod_r   = PW'(raw_r) * PW'(scale);
        prod_g   = PW'(raw_g) * PW'(scale);
        prod_b   = PW'(raw_b) * PW'(scale);
        duty_r_d = DW'(prod_r >> 8);
        duty_g_d = DW'(prod_g >> 8);
        duty_b_d = DW'(prod_b >> 8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q       <= '0;
            step_q       <= '0;
            seg_q        <= 3'd0;
            step_pulse_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            duty_r_q     <= '0;
            duty_g_q     <= '0;
            duty_b_q     <= '0;
        end else begin
            tick_q       <= tick_d;
            step_q       <= step_d;
            seg_q        <= seg_d;
            step_pulse_q <= step_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            duty_r_q     <= duty_r_d;
            duty_g_q     <= duty_g_d;
            duty_b_q     <= duty_b_d;
        end
    end

    assign duty_r     = duty_r_q;
    assign duty_g     = duty_g_q;
    assign duty_b     = duty_b_q;
    assign seg        = seg_q;
    assign step_pulse = step_pulse_q;
    assign wrap_pulse = wrap_pulse_q;

`ifdef COLOR_WHEEL_PWM_OUT_EN
    logic [DW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DW-1:0] lat_r_q, lat_r_d, lat_g_q, lat_g_d, lat_b_q, lat_b_d;
    logic          pwm_r_q, pwm_r_d, pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d;
    logic          pwm_wrap;

    // Duty is latched only as the counter wraps, so a period is never cut short.
    always_comb begin
        pwm_wrap  = (pwm_cnt_q == DUTY_MAX - DW'(1));
        pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + DW'(1);
        lat_r_d   = pwm_wrap ? duty_r_q : lat_r_q;
        lat_g_d   = pwm_wrap ? duty_g_q : lat_g_q;
        lat_b_d   = pwm_wrap ? duty_b_q : lat_b_q;
        pwm_r_d   = (pwm_cnt_q < lat_r_q);
        pwm_g_d   = (pwm_cnt_q < lat_g_q);
        pwm_b_d   = (pwm_cnt_q < lat_b_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            lat_r_q   <= '0;
            lat_g_q   <= '0;
            lat_b_q   <= '0;
            pwm_r_q   <= 1'b0;
            pwm_g_q   <= 1'b0;
            pwm_b_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            lat_r_q   <= lat_r_d;
            lat_g_q   <= lat_g_d;
            lat_b_q   <= lat_b_d;
            pwm_r_q   <= pwm_r_d;
            pwm_g_q   <= pwm_g_d;
            pwm_b_q   <= pwm_b_d;
        end
    end

    assign pwm_r = pwm_r_q;
    assign pwm_g = pwm_g_q;
    assign pwm_b = pwm_b_q;
`else
    // Duty-only build: no PWM counter or pin outputs.
`endif

endmodule

// File: tb/tb_color_wheel_fader.sv
module tb_color_wheel_fader;

    localparam int S   = 4;
    localparam int M   = 8;
    localparam int INC = 2;
    localparam int TD  = 250;
    localparam int N   = 6 * S;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       sync_clr = 1'b0;
    logic [7:0] brightness = 8'd255;
    logic [3:0] duty_r, duty_g, duty_b;
    logic [2:0] seg;
    logic       step_pulse, wrap_pulse;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: hue position 0..N-1 and a tick count.
    int m_tick, m_pos;
    int e_dr, e_dg, e_db;
    bit e_sp, e_wp;

    color_wheel_fader #(
        .CLK_FREQ(6000), .PERIOD_MS(1000), .STEPS_PER_SEG(S), .PWM_INTERVAL(M)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .sync_clr(sync_clr),
        .brightness(brightness), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .seg(seg), .step_pulse(step_pulse), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    // Red channel shape over the wheel; green and blue are the same
    // trapezoid delayed by two and four segments.
    function automatic int trap(input int p);
        int s, k;
        s = p / S;
        k = p % S;
        case (s)
            0, 5:    return M;
            1:       return M - k * INC;
            4:       return k * INC;
            default: return 0;
        endcase
    endfunction

    function automatic int scaled(input int raw, input int b);
        return (raw * (b + 1)) / 256;
    endfunction

    task automatic model_reset();
        m_tick = 0; m_pos = 0;
        e_dr = 0; e_dg = 0; e_db = 0; e_sp = 0; e_wp = 0;
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        e_dr = scaled(trap(m_pos), int'(brightness));
        e_dg = scaled(trap((m_pos + N - 2 * S) % N), int'(brightness));
        e_db = scaled(trap((m_pos + N - 4 * S) % N), int'(brightness));
        e_sp = 0;
        e_wp = 0;
        if (sync_clr) begin
            m_tick = 0;
            m_pos  = 0;
        end else if (en) begin
            if (m_tick == TD - 1) begin
                m_tick = 0;
                e_sp   = 1;
                if (!dir) begin
                    e_wp  = (m_pos == N - 1);
                    m_pos = (m_pos + 1) % N;
                end else begin
                    e_wp  = (m_pos == 0);
                    m_pos = (m_pos + N - 1) % N;
                end
            end else begin
                m_tick++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic en_i, input logic dir_i, input logic [7:0] b_i);
        @(negedge clk);
        rst_n = 1'b0;
        en = en_i; dir = dir_i; brightness = b_i; sync_clr = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b0, 8'd255);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({seg, step_pulse, wrap_pulse, duty_r, duty_g, duty_b} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_state: seg=%0d sp=%0b wp=%0b duty=(%0d,%0d,%0d) want all 0",
                     seg, step_pulse, wrap_pulse, duty_r, duty_g, duty_b);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        clk_cycle();
        n_vec++;
        if (duty_r !== 4'd8 || duty_g !== 4'd0 || duty_b !== 4'd0) begin
            n_err++;
            $display("FAIL first_duty: got (%0d,%0d,%0d) want (8,0,0)", duty_r, duty_g, duty_b);
        end
    endtask

    task automatic test_forward();
        int nsp, nwp, ncap;
        bit cap;
        int g_seq[4] = '{2, 4, 6, 8};
        do_reset(1'b1, 1'b0, 8'd255);
        nsp = 0; nwp = 0; ncap = 0; cap = 0;
        for (int c = 1; c <= N * TD + 1; c++) begin
            clk_cycle();
            n_vec++;
            if (seg !== 3'(m_pos / S) || step_pulse !== e_sp || wrap_pulse !== e_wp ||
                duty_r !== 4'(e_dr) || duty_g !== 4'(e_dg) || duty_b !== 4'(e_db)) begin
                n_err++;
                $display("FAIL fwd_cycle%0d: seg=%0d sp=%0b wp=%0b duty=(%0d,%0d,%0d) want seg=%0d sp=%0b wp=%0b duty=(%0d,%0d,%0d)",
                         c, seg, step_pulse, wrap_pulse, duty_r, duty_g, duty_b,
                         m_pos / S, e_sp, e_wp, e_dr, e_dg, e_db);
            end
            if (cap && ncap < 4) begin
                n_vec++;
                if (duty_g !== 4'(g_seq[ncap])) begin
                    n_err++;
                    $display("FAIL g_seq%0d: got %0d want %0d", ncap, duty_g, g_seq[ncap]);
                end
                if (ncap == 3) begin
                    n_vec++;
                    if (seg !== 3'd1 || duty_r !== 4'd8 || duty_b !== 4'd0) begin
                        n_err++;
                        $display("FAIL seg1_entry: seg=%0d duty=(%0d,%0d,%0d) want seg=1 (8,8,0)",
                                 seg, duty_r, duty_g, duty_b);
                    end
                end
                ncap++;
            end
            cap = step_pulse;
            if (step_pulse) nsp++;
            if (wrap_pulse) nwp++;
        end
        n_vec++;
        if (nsp != N || nwp != 1) begin
            n_err++;
            $display("FAIL fwd_counts: steps=%0d wraps=%0d want %0d and 1", nsp, nwp, N);
        end
    endtask

    task automatic test_reverse();
        do_reset(1'b1, 1'b1, 8'd255);
        repeat (TD) clk_cycle();
        n_vec++;
        if (seg !== 3'd5 || step_pulse !== 1'b1 || wrap_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL rev_first: seg=%0d sp=%0b wp=%0b want 5 1 1", seg, step_pulse, wrap_pulse);
        end
        clk_cycle();
        n_vec++;
        if (duty_r !== 4'd8 || duty_g !== 4'd0 || duty_b !== 4'd2 || step_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL rev_duty: got (%0d,%0d,%0d) sp=%0b want (8,0,2) sp=0",
                     duty_r, duty_g, duty_b, step_pulse);
        end
    endtask

    task automatic test_hold();
        int cnt;
        bit seen;
        do_reset(1'b1, 1'b0, 8'd255);
        repeat (100) clk_cycle();
        en = 1'b0;
        seen = 0;
        repeat (1000) begin
            clk_cycle();
            if (step_pulse !== 1'b0 || wrap_pulse !== 1'b0) seen = 1;
        end
        n_vec++;
        if (seen || seg !== 3'd0) begin
            n_err++;
            $display("FAIL hold_quiet: pulse_seen=%0b seg=%0d want 0 0", seen, seg);
        end
        en = 1'b1;
        cnt = 0;
        while (step_pulse !== 1'b1 && cnt < 400) begin
            clk_cycle();
            cnt++;
        end
        n_vec++;
        if (cnt != TD - 100) begin
            n_err++;
            $display("FAIL hold_resume: step after %0d cycles want %0d", cnt, TD - 100);
        end
    endtask

    task automatic test_brightness();
        do_reset(1'b0, 1'b0, 8'd255);
        clk_cycle();
        brightness = 8'd127;
        clk_cycle();
        n_vec++;
        if (duty_r !== 4'd4 || duty_g !== 4'd0) begin
            n_err++;
            $display("FAIL bright127: got r=%0d g=%0d want 4 0", duty_r, duty_g);
        end
        brightness = 8'd0;
        clk_cycle();
        n_vec++;
        if (duty_r !== 4'd0) begin
            n_err++;
            $display("FAIL bright0: got r=%0d want 0", duty_r);
        end
        brightness = 8'd255;
    endtask

    task automatic test_sync_clr();
        int cnt;
        do_reset(1'b1, 1'b0, 8'd255);
        repeat (3 * S * TD + TD - 1) clk_cycle();
        n_vec++;
        if (seg !== 3'd3) begin
            n_err++;
            $display("FAIL sync_pre: seg=%0d want 3", seg);
        end
        sync_clr = 1'b1;
        clk_cycle();
        sync_clr = 1'b0;
        n_vec++;
        if (seg !== 3'd0 || step_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL sync_clr: seg=%0d sp=%0b wp=%0b want 0 0 0", seg, step_pulse, wrap_pulse);
        end
        cnt = 0;
        while (step_pulse !== 1'b1 && cnt < 400) begin
            clk_cycle();
            cnt++;
            if (cnt == 1) begin
                n_vec++;
                if (duty_r !== 4'd8 || duty_g !== 4'd0 || duty_b !== 4'd0) begin
                    n_err++;
                    $display("FAIL sync_duty: got (%0d,%0d,%0d) want (8,0,0)", duty_r, duty_g, duty_b);
                end
            end
        end
        n_vec++;
        if (cnt != TD) begin
            n_err++;
            $display("FAIL sync_tick: next step after %0d cycles want %0d", cnt, TD);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b0, 8'd255);
        repeat (TD * 5 + 10) clk_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({seg, step_pulse, wrap_pulse, duty_r, duty_g, duty_b} !== 17'd0) begin
            n_err++;
            $display("FAIL async_reset: seg=%0d sp=%0b wp=%0b duty=(%0d,%0d,%0d) want all 0",
                     seg, step_pulse, wrap_pulse, duty_r, duty_g, duty_b);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        clk_cycle();
        n_vec++;
        if (duty_r !== 4'd8 || duty_g !== 4'd0 || duty_b !== 4'd0 || seg !== 3'd0) begin
            n_err++;
            $display("FAIL async_release: duty=(%0d,%0d,%0d) seg=%0d want (8,0,0) 0",
                     duty_r, duty_g, duty_b, seg);
        end
    endtask

    task automatic test_random();
        do_reset(1'b1, 1'b0, 8'd255);
        for (int c = 0; c < 15000; c++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) dir = ~dir;
            if ($urandom_range(0, 49) == 0) brightness = 8'($urandom_range(0, 255));
            sync_clr = ($urandom_range(0, 1999) == 0);
            clk_cycle();
            n_vec++;
            if (seg !== 3'(m_pos / S) || step_pulse !== e_sp || wrap_pulse !== e_wp ||
                duty_r !== 4'(e_dr) || duty_g !== 4'(e_dg) || duty_b !== 4'(e_db)) begin
                n_err++;
                $display("FAIL rand_cycle%0d: seg=%0d sp=%0b wp=%0b duty=(%0d,%0d,%0d) want seg=%0d sp=%0b wp=%0b duty=(%0d,%0d,%0d)",
                         c, seg, step_pulse, wrap_pulse, duty_r, duty_g, duty_b,
                         m_pos / S, e_sp, e_wp, e_dr, e_dg, e_db);
            end
        end
        sync_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forward();
        test_reverse();
        test_hold();
        test_brightness();
        test_sync_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
